slink_bist_tx: RTL and testbench



---
 rtl/slink_bist_tx.sv | 327 ++++++++++++++++++++++++++++++++
 tb/tb_slink_bist_tx.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slink_bist_tx.sv
// slink_bist_tx: BIST packet generator for the S-Link application TX interface.
// Generates sop/data_id/word_count/app_data/valid packets whose payload, word
// count sweep and data-ID sweep match the BIST RX checker, with optional
// single-bit error injection.
//
// Payload pattern select encodings (swi_bist_mode_payload):
//   4'd0 = 1010 (0xAA), 4'd1 = 1100 (0xCC), 4'd2 = 1111_0000 (0xF0),
//   4'd3 = COUNT (byte index), anything else = 0xD0.

// Two-flop synchroniser with asynchronous active-high reset.
module slink_demet_reset (
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    output logic sig_out
);

    logic meta_q;
    logic sync_q;

    // Double-register the asynchronous input into the clk domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= sig_in;
            sync_q <= meta_q;
        end
    end

    assign sig_out = sync_q;

endmodule

module slink_bist_tx #(
    parameter int APP_DATA_WIDTH = 32,
    parameter int APP_DATA_BYTES = APP_DATA_WIDTH >> 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      swi_bist_en,
    input  logic                      swi_bist_reset,
    input  logic                      swi_bist_err_inject,
    input  logic [3:0]                swi_bist_mode_payload,
    input  logic                      swi_bist_mode_wc,
    input  logic [15:0]               swi_bist_wc_min,
    input  logic [15:0]               swi_bist_wc_max,
    input  logic                      swi_bist_mode_di,
    input  logic [7:0]                swi_bist_di_min,
    input  logic [7:0]                swi_bist_di_max,
    output logic                      bist_active,
    output logic [15:0]               bist_pkt_count,
    output logic                      sop,
    output logic [7:0]                data_id,
    output logic [15:0]               word_count,
    output logic [APP_DATA_WIDTH-1:0] app_data,
    output logic                      valid,
    input  logic                      advance
);

    localparam logic [3:0]  BIST_PAYLOAD_1010      = 4'd0;
    localparam logic [3:0]  BIST_PAYLOAD_1100      = 4'd1;
    localparam logic [3:0]  BIST_PAYLOAD_1111_0000 = 4'd2;
    localparam logic [3:0]  BIST_PAYLOAD_COUNT     = 4'd3;
    localparam logic [16:0] BEAT_BYTES             = 17'(APP_DATA_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SOP,
        ST_PAYLOAD
    } state_t;

    // Synchronised control inputs
    logic en_sync;
    logic rst_sync;
    logic inj_sync;

    slink_demet_reset u_demet_en (
        .clk     (clk),
        .reset   (reset),
        .sig_in  (swi_bist_en),
        .sig_out (en_sync)
    );

    slink_demet_reset u_demet_rst (
        .clk     (clk),
        .reset   (reset),
        .sig_in  (swi_bist_reset),
        .sig_out (rst_sync)
    );

    slink_demet_reset u_demet_inj (
        .clk     (clk),
        .reset   (reset),
        .sig_in  (swi_bist_err_inject),
        .sig_out (inj_sync)
    );

    // State and registered outputs
    state_t                    state_q, state_d;
    logic                      sop_q, sop_d;
    logic                      valid_q, valid_d;
    logic [7:0]                data_id_q, data_id_d;
    logic [15:0]               word_count_q, word_count_d;
    logic [APP_DATA_WIDTH-1:0] app_data_q, app_data_d;
    logic                      active_q, active_d;
    logic [15:0]               pkt_count_q, pkt_count_d;
    logic [15:0]               wc_q, wc_d;
    logic [7:0]                di_q, di_d;
    logic [16:0]               byte_cnt_q, byte_cnt_d;
    logic                      inj_prev_q, inj_prev_d;
    logic                      inj_pend_q, inj_pend_d;
    logic                      inj_beat_q, inj_beat_d;

    // Combinational helpers
    logic                      run_ok;
    logic                      xfer;
    logic                      inj_edge;
    logic                      inj_clr;
    logic                      pend_eff;
    logic                      pkt_done;
    logic                      load_sop;
    logic                      load_pl;
    logic [15:0]               sop_wc;
    logic [7:0]                sop_di;
    logic [16:0]               pl_start;
    logic [16:0]               cnt_nxt;
    logic [15:0]               wc_next;
    logic [7:0]                di_next;
    logic [APP_DATA_WIDTH-1:0] pl_data;

    // Pattern for one beat starting at byte index start; bytes past wc are zero.
    function automatic logic [APP_DATA_WIDTH-1:0] beat_data(
        input logic [16:0] start,
        input logic [15:0] wc,
        input logic [3:0]  mode
    );
        logic [APP_DATA_WIDTH-1:0] d;
        logic [16:0]               k;
        logic [7:0]                b;
        d = '0;
        for (int unsigned j = 0; j < APP_DATA_BYTES; j++) begin
            k = start + 17'(j);
            case (mode)
                BIST_PAYLOAD_1010:      b = 8'hAA;
                BIST_PAYLOAD_1100:      b = 8'hCC;
                BIST_PAYLOAD_1111_0000: b = 8'hF0;
                BIST_PAYLOAD_COUNT:     b = k[7:0];
                default:                b = 8'hD0;
            endcase
            if (k < {1'b0, wc}) begin
                d[j*8 +: 8] = b;
            end
        end
        return d;
    endfunction

    // Next-state, next-beat, sweep tracking and error-injection logic.
    // The pending inject flag is only released when the beat that carried the
    // flipped bit is actually transferred, so stalls cannot lose the error.
    always_comb begin
        state_d      = state_q;
        sop_d        = sop_q;
        valid_d      = valid_q;
        data_id_d    = data_id_q;
        word_count_d = word_count_q;
        app_data_d   = app_data_q;
        pkt_count_d  = pkt_count_q;
        wc_d         = wc_q;
        di_d         = di_q;
        byte_cnt_d   = byte_cnt_q;
        inj_beat_d   = inj_beat_q;
        inj_prev_d   = inj_sync;

        run_ok   = en_sync & ~rst_sync;
        xfer     = valid_q & advance;
        inj_edge = inj_sync & ~inj_prev_q;
        inj_clr  = xfer & (state_q == ST_PAYLOAD) & inj_beat_q;
        pend_eff = inj_pend_q & ~inj_clr;
        pkt_done = 1'b0;
        load_sop = 1'b0;
        load_pl  = 1'b0;
        sop_wc   = wc_q;
        sop_di   = di_q;
        pl_start = byte_cnt_q;
        cnt_nxt  = byte_cnt_q + BEAT_BYTES;
        pl_data  = '0;

        wc_next = wc_q;
        if (swi_bist_mode_wc) begin
            wc_next = (wc_q == swi_bist_wc_max) ? swi_bist_wc_min : wc_q + 16'd1;
        end
        di_next = di_q;
        if (swi_bist_mode_di) begin
            di_next = (di_q == swi_bist_di_max) ? swi_bist_di_min : di_q + 8'd1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (run_ok) begin
                    wc_d     = swi_bist_wc_min;
                    di_d     = swi_bist_di_min;
                    sop_wc   = swi_bist_wc_min;
                    sop_di   = swi_bist_di_min;
                    load_sop = 1'b1;
                end
            end
            ST_SOP: begin
                if (xfer) begin
                    byte_cnt_d = BEAT_BYTES;
                    if (BEAT_BYTES >= {1'b0, word_count_q}) begin
                        pkt_done = 1'b1;
                    end else begin
                        load_pl  = 1'b1;
                        pl_start = BEAT_BYTES;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (xfer) begin
                    byte_cnt_d = cnt_nxt;
                    if (cnt_nxt >= {1'b0, word_count_q}) begin
                        pkt_done = 1'b1;
                    end else begin
                        load_pl  = 1'b1;
                        pl_start = cnt_nxt;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (pkt_done) begin
            if (pkt_count_q != 16'hFFFF) begin
                pkt_count_d = pkt_count_q + 16'd1;
            end
            wc_d = wc_next;
            di_d = di_next;
            if (run_ok) begin
                sop_wc   = wc_next;
                sop_di   = di_next;
                load_sop = 1'b1;
            end else begin
                state_d    = ST_IDLE;
                sop_d      = 1'b0;
                valid_d    = 1'b0;
                app_data_d = '0;
                inj_beat_d = 1'b0;
            end
        end

        if (load_sop) begin
            state_d      = ST_SOP;
            sop_d        = 1'b1;
            valid_d      = 1'b1;
            data_id_d    = sop_di;
            word_count_d = sop_wc;
            app_data_d   = beat_data(17'd0, sop_wc, swi_bist_mode_payload);
            inj_beat_d   = 1'b0;
        end

        if (load_pl) begin
            pl_data    = beat_data(pl_start, word_count_q, swi_bist_mode_payload);
            pl_data[0] = pl_data[0] ^ pend_eff;
            state_d    = ST_PAYLOAD;
            sop_d      = 1'b0;
            valid_d    = 1'b1;
            app_data_d = pl_data;
            inj_beat_d = pend_eff;
        end

        inj_pend_d = pend_eff | inj_edge;

        if (rst_sync) begin
            pkt_count_d = '0;
        end

        active_d = (state_d != ST_IDLE);
    end

    // Register state, outputs, trackers and inject bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            sop_q        <= 1'b0;
            valid_q      <= 1'b0;
            data_id_q    <= '0;
            word_count_q <= '0;
            app_data_q   <= '0;
            active_q     <= 1'b0;
            pkt_count_q  <= '0;
            wc_q         <= '0;
            di_q         <= '0;
            byte_cnt_q   <= '0;
            inj_prev_q   <= 1'b0;
            inj_pend_q   <= 1'b0;
            inj_beat_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sop_q        <= sop_d;
            valid_q      <= valid_d;
            data_id_q    <= data_id_d;
            word_count_q <= word_count_d;
            app_data_q   <= app_data_d;
            active_q     <= active_d;
            pkt_count_q  <= pkt_count_d;
            wc_q         <= wc_d;
            di_q         <= di_d;
            byte_cnt_q   <= byte_cnt_d;
            inj_prev_q   <= inj_prev_d;
            inj_pend_q   <= inj_pend_d;
            inj_beat_q   <= inj_beat_d;
        end
    end

    assign bist_active    = active_q;
    assign bist_pkt_count = pkt_count_q;
    assign sop            = sop_q;
    assign data_id        = data_id_q;
    assign word_count     = word_count_q;
    assign app_data       = app_data_q;
    assign valid          = valid_q;

endmodule

// File: tb/tb_slink_bist_tx.sv
// Directed testbench for slink_bist_tx (32-bit data bus).
module tb_slink_bist_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        swi_bist_en = 1'b0;
    logic        swi_bist_reset = 1'b0;
    logic        swi_bist_err_inject = 1'b0;
    logic [3:0]  swi_bist_mode_payload = 4'd0;
    logic        swi_bist_mode_wc = 1'b0;
    logic [15:0] swi_bist_wc_min = 16'd0;
    logic [15:0] swi_bist_wc_max = 16'd0;
    logic        swi_bist_mode_di = 1'b0;
    logic [7:0]  swi_bist_di_min = 8'd0;
    logic [7:0]  swi_bist_di_max = 8'd0;
    logic        bist_active;
    logic [15:0] bist_pkt_count;
    logic        sop;
    logic [7:0]  data_id;
    logic [15:0] word_count;
    logic [31:0] app_data;
    logic        valid;
    logic        advance = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] b_data;
    logic        b_sop;
    logic [15:0] b_wc;
    logic [7:0]  b_di;
    int          b_wait;

    always #5 clk = ~clk;

    slink_bist_tx #(.APP_DATA_WIDTH(32)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .swi_bist_en           (swi_bist_en),
        .swi_bist_reset        (swi_bist_reset),
        .swi_bist_err_inject   (swi_bist_err_inject),
        .swi_bist_mode_payload (swi_bist_mode_payload),
        .swi_bist_mode_wc      (swi_bist_mode_wc),
        .swi_bist_wc_min       (swi_bist_wc_min),
        .swi_bist_wc_max       (swi_bist_wc_max),
        .swi_bist_mode_di      (swi_bist_mode_di),
        .swi_bist_di_min       (swi_bist_di_min),
        .swi_bist_di_max       (swi_bist_di_max),
        .bist_active           (bist_active),
        .bist_pkt_count        (bist_pkt_count),
        .sop                   (sop),
        .data_id               (data_id),
        .word_count            (word_count),
        .app_data              (app_data),
        .valid                 (valid),
        .advance               (advance)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for the next visible beat at a falling edge and capture it.
    task automatic next_beat();
        b_wait = 0;
        do begin
            @(negedge clk);
            b_wait++;
        end while (!valid && b_wait < 40);
        if (!valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL beat_timeout: got no valid beat expected one within 40 cycles");
        end
        b_data = app_data;
        b_sop  = sop;
        b_wc   = word_count;
        b_di   = data_id;
    endtask

    // Disable and wait (bounded) for the generator to reach idle.
    task automatic drain();
        int i;
        swi_bist_en = 1'b0;
        advance     = 1'b1;
        i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (valid && i < 200);
        if (valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got valid=1 expected 0 within 200 cycles");
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic clear_cnt();
        swi_bist_reset = 1'b1;
        repeat (4) @(negedge clk);
        check("pkt_clear", 32'(bist_pkt_count), 32'd0);
        swi_bist_reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic config_gen(input logic [3:0] mode, input logic mwc, input logic [15:0] wmin,
                              input logic [15:0] wmax, input logic mdi, input logic [7:0] dmin,
                              input logic [7:0] dmax);
        swi_bist_mode_payload = mode;
        swi_bist_mode_wc      = mwc;
        swi_bist_wc_min       = wmin;
        swi_bist_wc_max       = wmax;
        swi_bist_mode_di      = mdi;
        swi_bist_di_min       = dmin;
        swi_bist_di_max       = dmax;
    endtask

    // Sweep expectations: per packet word count, data id, and last beat data.
    logic [15:0] sw_wc   [4] = '{16'd4, 16'd5, 16'd6, 16'd4};
    logic [7:0]  sw_di   [4] = '{8'h10, 8'h11, 8'h10, 8'h11};
    logic [31:0] sw_last [4] = '{32'hCCCCCCCC, 32'h000000CC, 32'h0000CCCC, 32'hCCCCCCCC};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected end of test by 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid",  32'(valid), 32'd0);
        check("rst_sop",    32'(sop), 32'd0);
        check("rst_data",   app_data, 32'd0);
        check("rst_pkt",    32'(bist_pkt_count), 32'd0);
        check("rst_active", 32'(bist_active), 32'd0);
        check("rst_wc",     32'(word_count), 32'd0);
        check("rst_di",     32'(data_id), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 1010 pattern, 10 bytes, di 0x20
        config_gen(4'd0, 1'b0, 16'd10, 16'd10, 1'b0, 8'h20, 8'h20);
        swi_bist_en = 1'b1;
        next_beat();
        check("a_sop0",  32'(b_sop), 32'd1);
        check("a_d0",    b_data, 32'hAAAAAAAA);
        check("a_wc",    32'(b_wc), 32'd10);
        check("a_di",    32'(b_di), 32'h20);
        check("a_active", 32'(bist_active), 32'd1);
        next_beat();
        check("a_sop1",  32'(b_sop), 32'd0);
        check("a_d1",    b_data, 32'hAAAAAAAA);
        next_beat();
        check("a_d2",    b_data, 32'h0000AAAA);
        next_beat();
        check("a_nobubble_wait", 32'(b_wait), 32'd1);
        check("a_next_sop", 32'(b_sop), 32'd1);
        check("a_pkt",   32'(bist_pkt_count), 32'd1);
        drain();

        // COUNT pattern, 6 bytes, packet counting
        clear_cnt();
        config_gen(4'd3, 1'b0, 16'd6, 16'd6, 1'b0, 8'h21, 8'h21);
        swi_bist_en = 1'b1;
        next_beat();
        check("b_sop",   32'(b_sop), 32'd1);
        check("b_d0",    b_data, 32'h03020100);
        next_beat();
        check("b_d1",    b_data, 32'h00000504);
        next_beat();
        check("b_p2_sop", 32'(b_sop), 32'd1);
        check("b_p2_d0",  b_data, 32'h03020100);
        check("b_pkt1",   32'(bist_pkt_count), 32'd1);
        next_beat();
        next_beat();
        check("b_pkt2",   32'(bist_pkt_count), 32'd2);
        drain();

        // Word count and data id sweep, 1100 pattern
        clear_cnt();
        config_gen(4'd1, 1'b1, 16'd4, 16'd6, 1'b1, 8'h10, 8'h11);
        swi_bist_en = 1'b1;
        for (int p = 0; p < 4; p++) begin
            next_beat();
            check($sformatf("c_sop%0d", p), 32'(b_sop), 32'd1);
            check($sformatf("c_wc%0d", p), 32'(b_wc), 32'(sw_wc[p]));
            check($sformatf("c_di%0d", p), 32'(b_di), 32'(sw_di[p]));
            if (sw_wc[p] > 16'd4) begin
                check($sformatf("c_first%0d", p), b_data, 32'hCCCCCCCC);
                next_beat();
                check($sformatf("c_tail_sop%0d", p), 32'(b_sop), 32'd0);
            end
            check($sformatf("c_last%0d", p), b_data, sw_last[p]);
        end
        drain();

        // Backpressure: hold advance low for 5 cycles on the second beat
        clear_cnt();
        config_gen(4'd3, 1'b0, 16'd12, 16'd12, 1'b0, 8'h30, 8'h30);
        swi_bist_en = 1'b1;
        next_beat();
        check("d_d0", b_data, 32'h03020100);
        next_beat();
        check("d_d1", b_data, 32'h07060504);
        advance = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("d_hold_valid", 32'(valid), 32'd1);
            check("d_hold_sop",   32'(sop), 32'd0);
            check("d_hold_data",  app_data, 32'h07060504);
            check("d_hold_wc",    32'(word_count), 32'd12);
            check("d_hold_di",    32'(data_id), 32'h30);
        end
        advance = 1'b1;
        next_beat();
        check("d_d2_wait", 32'(b_wait), 32'd1);
        check("d_d2",      b_data, 32'h0B0A0908);
        check("d_d2_sop",  32'(b_sop), 32'd0);
        next_beat();
        check("d_next_sop", 32'(b_sop), 32'd1);
        check("d_next_d0",  b_data, 32'h03020100);
        drain();

        // Disable mid-packet, then re-enable restarts at the minimums
        clear_cnt();
        config_gen(4'd3, 1'b1, 16'd12, 16'd13, 1'b1, 8'h40, 8'h41);
        swi_bist_en = 1'b1;
        next_beat();
        check("e_wc0", 32'(b_wc), 32'd12);
        next_beat();
        check("e_d1", b_data, 32'h07060504);
        swi_bist_en = 1'b0;
        advance = 1'b0;
        repeat (3) @(negedge clk);
        advance = 1'b1;
        next_beat();
        check("e_d2", b_data, 32'h0B0A0908);
        @(negedge clk);
        check("e_stop_valid",  32'(valid), 32'd0);
        check("e_stop_active", 32'(bist_active), 32'd0);
        repeat (3) @(negedge clk);
        check("e_still_idle", 32'(valid), 32'd0);
        check("e_pkt", 32'(bist_pkt_count), 32'd1);
        swi_bist_en = 1'b1;
        next_beat();
        check("e_re_sop", 32'(b_sop), 32'd1);
        check("e_re_wc",  32'(b_wc), 32'd12);
        check("e_re_di",  32'(b_di), 32'h40);
        drain();

        // Zero word count: single all-zero SOP beat per packet
        config_gen(4'd0, 1'b0, 16'd0, 16'd0, 1'b0, 8'h05, 8'h05);
        swi_bist_en = 1'b1;
        next_beat();
        check("f_sop0", 32'(b_sop), 32'd1);
        check("f_d0",   b_data, 32'd0);
        check("f_wc0",  32'(b_wc), 32'd0);
        next_beat();
        check("f_wait1", 32'(b_wait), 32'd1);
        check("f_sop1",  32'(b_sop), 32'd1);
        check("f_d1",    b_data, 32'd0);
        drain();

        // Error injection: two pulses while idle, only one bit error results
        clear_cnt();
        config_gen(4'd0, 1'b0, 16'd12, 16'd12, 1'b0, 8'h06, 8'h06);
        swi_bist_err_inject = 1'b1;
        repeat (4) @(negedge clk);
        swi_bist_err_inject = 1'b0;
        repeat (4) @(negedge clk);
        swi_bist_err_inject = 1'b1;
        repeat (4) @(negedge clk);
        swi_bist_err_inject = 1'b0;
        repeat (4) @(negedge clk);
        swi_bist_en = 1'b1;
        next_beat();
        check("g_sop_clean", b_data, 32'hAAAAAAAA);
        next_beat();
        check("g_flipped",   b_data, 32'hAAAAAAAB);
        next_beat();
        check("g_after",     b_data, 32'hAAAAAAAA);
        next_beat();
        check("g_p2_sop",    32'(b_sop), 32'd1);
        next_beat();
        check("g_p2_clean",  b_data, 32'hAAAAAAAA);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
